// File: rtl/uart_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder_if
// Groups the byte-level handshake between the command responder and the
// UART receiver/transmitter pair.
//   data_received  : byte from uart_rx, valid while rx_done is high
//   rx_done        : one-cycle strobe, new byte available
//   parity_error   : parity flag from uart_rx, qualified by rx_done
//   tx_busy        : uart_tx is shifting a frame
//   data_to_tx     : reply byte towards uart_tx
//   start_tx       : one-cycle transmit request towards uart_tx
// Modports:
//   master : UART side (drives received data and tx_busy)
//   slave  : responder side (drives the reply and start_tx)
// ---------------------------------------------------------------------------
interface uart_cmd_responder_if;
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic       tx_busy;
    logic [7:0] data_to_tx;
    logic       start_tx;

    modport master (
        output data_received,
        output rx_done,
        output parity_error,
        output tx_busy,
        input  data_to_tx,
        input  start_tx
    );

    modport slave (
        input  data_received,
        input  rx_done,
        input  parity_error,
        input  tx_busy,
        output data_to_tx,
        output start_tx
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
// Decodes single-byte commands from a UART receiver, drives the SPWM gate
// enable and answers each frame through the UART transmitter (echo for a
// valid command, NACK otherwise). A watchdog forces the gate off when no
// valid command arrives for WDT_CYCLES cycles.
// Ports:
//   clk        : system clock, all logic on posedge
//   reset      : synchronous, active-high reset
//   bus        : UART handshake (slave modport of uart_cmd_responder_if)
//   gate_en    : registered enable for the SPWM stage
//   wdt_trip   : one-cycle pulse when the watchdog clears gate_en
//   overrun    : sticky, a byte arrived while a transaction was in flight
//   tx_fault   : sticky, tx_busy did not rise within BUSY_TMO cycles
//   err_count  : saturating count of rejected frames
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
    parameter logic [7:0]  CMD_ON     = 8'b10101010,
    parameter logic [7:0]  CMD_OFF    = 8'b01010101,
    parameter logic [7:0]  CMD_TOGGLE = 8'b11000011,
    parameter logic [7:0]  NACK       = 8'hFF,
    parameter int unsigned WDT_CYCLES = 32'd48000000,
    parameter int unsigned BUSY_TMO   = 32'd16
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_cmd_responder_if.slave         bus,
    output logic                        gate_en,
    output logic                        wdt_trip,
    output logic                        overrun,
    output logic                        tx_fault,
    output logic [7:0]                  err_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [31:0] WDT_LAST  = 32'(WDT_CYCLES - 32'd1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TMO - 32'd1);

    state_t      state_r,      state_s;
    logic [7:0]  rx_byte_r,    rx_byte_s;
    logic        rx_perr_r,    rx_perr_s;
    logic [7:0]  data_to_tx_r, data_to_tx_s;
    logic        start_tx_r,   start_tx_s;
    logic        gate_en_r,    gate_en_s;
    logic        wdt_trip_r,   wdt_trip_s;
    logic        overrun_r,    overrun_s;
    logic        tx_fault_r,   tx_fault_s;
    logic [7:0]  err_count_r,  err_count_s;
    logic [15:0] busy_cnt_r,   busy_cnt_s;
    logic [31:0] wdt_cnt_r,    wdt_cnt_s;
    logic        cmd_hit_s;

    // True when the byte is one of the three recognised commands.
    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_ON) || (b == CMD_OFF) || (b == CMD_TOGGLE);
    endfunction

    // Gate enable value that results from applying command b to cur.
    function automatic logic apply_cmd(input logic [7:0] b, input logic cur);
        logic res;
        case (b)
            CMD_ON:     res = 1'b1;
            CMD_OFF:    res = 1'b0;
            CMD_TOGGLE: res = ~cur;
            default:    res = cur;
        endcase
        return res;
    endfunction

    // Next-state, reply, counters and flags for the next clock edge.
    always_comb begin
        state_s      = state_r;
        rx_byte_s    = rx_byte_r;
        rx_perr_s    = rx_perr_r;
        data_to_tx_s = data_to_tx_r;
        start_tx_s   = 1'b0;
        gate_en_s    = gate_en_r;
        wdt_trip_s   = 1'b0;
        overrun_s    = overrun_r;
        tx_fault_s   = tx_fault_r;
        err_count_s  = err_count_r;
        busy_cnt_s   = busy_cnt_r;
        wdt_cnt_s    = wdt_cnt_r;
        cmd_hit_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.rx_done) begin
                    rx_byte_s = bus.data_received;
                    rx_perr_s = bus.parity_error;
                    state_s   = ST_DECODE;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_DECODE: begin
                state_s = ST_SEND;
                // Parity is checked first so a corrupted frame that happens
                // to look like a command is still rejected.
                if (!rx_perr_r && is_cmd(rx_byte_r)) begin
                    cmd_hit_s    = 1'b1;
                    data_to_tx_s = rx_byte_r;
                    gate_en_s    = apply_cmd(rx_byte_r, gate_en_r);
                end else begin
                    data_to_tx_s = NACK;
                    err_count_s  = (err_count_r == 8'hFF) ? 8'hFF : err_count_r + 8'd1;
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    start_tx_s = 1'b1;
                    busy_cnt_s = 16'd0;
                    state_s    = ST_WAIT_BUSY;
                end else begin
                    state_s    = ST_SEND;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_s    = ST_WAIT_DONE;
                end else if (busy_cnt_r == BUSY_LAST) begin
                    tx_fault_s = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    busy_cnt_s = busy_cnt_r + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A byte arriving mid-transaction is dropped and only flagged.
        if (bus.rx_done && (state_r != ST_IDLE)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end

        // Watchdog: a valid command on the expiry cycle takes priority.
        if (cmd_hit_s) begin
            wdt_cnt_s = 32'd0;
        end else if (wdt_cnt_r == WDT_LAST) begin
            wdt_cnt_s = 32'd0;
            if (gate_en_r) begin
                gate_en_s  = 1'b0;
                wdt_trip_s = 1'b1;
            end else begin
                wdt_trip_s = 1'b0;
            end
        end else begin
            wdt_cnt_s = wdt_cnt_r + 32'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rx_byte_r    <= 8'h00;
            rx_perr_r    <= 1'b0;
            data_to_tx_r <= 8'h00;
            start_tx_r   <= 1'b0;
            gate_en_r    <= 1'b0;
            wdt_trip_r   <= 1'b0;
            overrun_r    <= 1'b0;
            tx_fault_r   <= 1'b0;
            err_count_r  <= 8'h00;
            busy_cnt_r   <= 16'd0;
            wdt_cnt_r    <= 32'd0;
        end else begin
            state_r      <= state_s;
            rx_byte_r    <= rx_byte_s;
            rx_perr_r    <= rx_perr_s;
            data_to_tx_r <= data_to_tx_s;
            start_tx_r   <= start_tx_s;
            gate_en_r    <= gate_en_s;
            wdt_trip_r   <= wdt_trip_s;
            overrun_r    <= overrun_s;
            tx_fault_r   <= tx_fault_s;
            err_count_r  <= err_count_s;
            busy_cnt_r   <= busy_cnt_s;
            wdt_cnt_r    <= wdt_cnt_s;
        end
    end

    assign bus.data_to_tx = data_to_tx_r;
    assign bus.start_tx   = start_tx_r;
    assign gate_en        = gate_en_r;
    assign wdt_trip       = wdt_trip_r;
    assign overrun        = overrun_r;
    assign tx_fault       = tx_fault_r;
    assign err_count      = err_count_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_responder
// Directed bench for uart_cmd_responder. A small uart_tx model answers
// start_tx with a 4-cycle tx_busy burst (or stays silent when tx_dead is set)
// and records every reply byte. Inputs change and outputs are sampled on the
// falling edge of clk.
// ---------------------------------------------------------------------------
module tb_uart_cmd_responder;

    logic       clk;
    logic       reset;
    logic       gate_en;
    logic       wdt_trip;
    logic       overrun;
    logic       tx_fault;
    logic [7:0] err_count;

    logic       tx_dead;
    logic       hold_chk_en;
    int         busy_left;
    int         n_start;
    int         starts_before;
    logic [7:0] last_reply;
    logic [7:0] replies[$];

    int         n_cmp;
    int         n_err;

    uart_cmd_responder_if bus();

    uart_cmd_responder #(
        .CMD_ON     (8'hAA),
        .CMD_OFF    (8'h55),
        .CMD_TOGGLE (8'hC3),
        .NACK       (8'hFF),
        .WDT_CYCLES (32'd100),
        .BUSY_TMO   (32'd16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .gate_en   (gate_en),
        .wdt_trip  (wdt_trip),
        .overrun   (overrun),
        .tx_fault  (tx_fault),
        .err_count (err_count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one received byte for a single clock, called on a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic perr);
        bus.data_received = b;
        bus.parity_error  = perr;
        bus.rx_done       = 1'b1;
        @(negedge clk);
        bus.rx_done       = 1'b0;
        bus.parity_error  = 1'b0;
    endtask

    // uart_tx model: records replies, raises tx_busy for 4 cycles, and
    // checks that the reply byte stays put while the frame is shifting.
    initial begin
        bus.tx_busy = 1'b0;
        busy_left   = 0;
        n_start     = 0;
        last_reply  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.start_tx) begin
                n_start    = n_start + 1;
                last_reply = bus.data_to_tx;
                replies.push_back(bus.data_to_tx);
                if (!tx_dead) begin
                    busy_left   = 4;
                    bus.tx_busy = 1'b1;
                end
            end else if (busy_left > 0) begin
                if (hold_chk_en) begin
                    check_value("tx_hold", {24'd0, bus.data_to_tx}, {24'd0, last_reply});
                end
                busy_left = busy_left - 1;
                if (busy_left == 0) begin
                    bus.tx_busy = 1'b0;
                end
            end
        end
    end

    // Directed stimulus and checks.
    initial begin
        n_cmp             = 0;
        n_err             = 0;
        reset             = 1'b1;
        tx_dead           = 1'b0;
        hold_chk_en       = 1'b1;
        bus.rx_done       = 1'b0;
        bus.data_received = 8'h00;
        bus.parity_error  = 1'b0;
        repeat (3) @(negedge clk);

        check_value("rst_gate",  {31'd0, gate_en},          32'd0);
        check_value("rst_start", {31'd0, bus.start_tx},     32'd0);
        check_value("rst_data",  {24'd0, bus.data_to_tx},   32'd0);
        check_value("rst_trip",  {31'd0, wdt_trip},         32'd0);
        check_value("rst_ovr",   {31'd0, overrun},          32'd0);
        check_value("rst_fault", {31'd0, tx_fault},         32'd0);
        check_value("rst_err",   {24'd0, err_count},        32'd0);
        reset = 1'b0;
        @(negedge clk);

        // CMD_ON: gate at N+2, start_tx pulse at N+3 with echo.
        send_byte(8'hAA, 1'b0);
        check_value("on_gate_n1",  {31'd0, gate_en},      32'd0);
        @(negedge clk);
        check_value("on_gate_n2",  {31'd0, gate_en},      32'd1);
        check_value("on_start_n2", {31'd0, bus.start_tx}, 32'd0);
        @(negedge clk);
        check_value("on_start_n3", {31'd0, bus.start_tx}, 32'd1);
        check_value("on_data_n3",  {24'd0, bus.data_to_tx}, 32'hAA);
        @(negedge clk);
        check_value("on_start_n4", {31'd0, bus.start_tx}, 32'd0);
        repeat (12) @(negedge clk);
        check_value("on_nrep", replies.size(),      32'd1);
        check_value("on_rep0", {24'd0, replies[0]}, 32'hAA);

        // Two toggles.
        send_byte(8'hC3, 1'b0);
        repeat (12) @(negedge clk);
        check_value("tog1_gate", {31'd0, gate_en}, 32'd0);
        send_byte(8'hC3, 1'b0);
        repeat (12) @(negedge clk);
        check_value("tog2_gate", {31'd0, gate_en},     32'd1);
        check_value("tog_nrep",  replies.size(),       32'd3);
        check_value("tog_rep1",  {24'd0, replies[1]},  32'hC3);
        check_value("tog_rep2",  {24'd0, replies[2]},  32'hC3);

        // Parity error, then unknown byte: two NACKs, gate untouched.
        send_byte(8'hAA, 1'b1);
        repeat (12) @(negedge clk);
        send_byte(8'h12, 1'b0);
        repeat (12) @(negedge clk);
        check_value("nack_gate", {31'd0, gate_en},    32'd1);
        check_value("nack_err",  {24'd0, err_count},  32'd2);
        check_value("nack_nrep", replies.size(),      32'd5);
        check_value("nack_rep3", {24'd0, replies[3]}, 32'hFF);
        check_value("nack_rep4", {24'd0, replies[4]}, 32'hFF);

        // Second byte during WAIT_DONE is discarded.
        check_value("ovr_before", {31'd0, overrun}, 32'd0);
        send_byte(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        send_byte(8'hAA, 1'b0);
        repeat (12) @(negedge clk);
        check_value("ovr_flag", {31'd0, overrun},    32'd1);
        check_value("ovr_gate", {31'd0, gate_en},    32'd0);
        check_value("ovr_nrep", replies.size(),      32'd6);
        check_value("ovr_rep5", {24'd0, replies[5]}, 32'h55);

        // tx_busy never rises: fault after 16 WAIT_BUSY cycles, back in IDLE.
        tx_dead = 1'b1;
        send_byte(8'hAA, 1'b0);
        repeat (17) @(negedge clk);
        check_value("flt_before", {31'd0, tx_fault}, 32'd0);
        @(negedge clk);
        check_value("flt_set",    {31'd0, tx_fault}, 32'd1);
        check_value("flt_gate",   {31'd0, gate_en},  32'd1);
        tx_dead = 1'b0;
        @(negedge clk);
        send_byte(8'h55, 1'b0);
        @(negedge clk);
        check_value("flt_idle_gate", {31'd0, gate_en}, 32'd0);
        repeat (12) @(negedge clk);
        check_value("flt_nrep", replies.size(), 32'd8);

        // Watchdog trip 100 cycles after the clearing command.
        send_byte(8'hAA, 1'b0);
        @(negedge clk);
        check_value("wdt_gate_on", {31'd0, gate_en}, 32'd1);
        repeat (99) @(negedge clk);
        check_value("wdt_gate_pre", {31'd0, gate_en},  32'd1);
        check_value("wdt_trip_pre", {31'd0, wdt_trip}, 32'd0);
        @(negedge clk);
        check_value("wdt_gate_off", {31'd0, gate_en},  32'd0);
        check_value("wdt_trip_set", {31'd0, wdt_trip}, 32'd1);
        @(negedge clk);
        check_value("wdt_trip_clr", {31'd0, wdt_trip}, 32'd0);

        // CMD_ON decoded exactly on the expiry cycle wins over the watchdog.
        send_byte(8'hAA, 1'b0);
        @(negedge clk);
        repeat (98) @(negedge clk);
        send_byte(8'hAA, 1'b0);
        @(negedge clk);
        check_value("race_trip", {31'd0, wdt_trip}, 32'd0);
        check_value("race_gate", {31'd0, gate_en},  32'd1);
        repeat (99) @(negedge clk);
        check_value("race2_trip_pre", {31'd0, wdt_trip}, 32'd0);
        @(negedge clk);
        check_value("race2_trip", {31'd0, wdt_trip}, 32'd1);
        check_value("race2_gate", {31'd0, gate_en},  32'd0);
        repeat (12) @(negedge clk);

        // Reset in WAIT_DONE aborts the transaction.
        send_byte(8'hAA, 1'b0);
        repeat (3) @(negedge clk);
        hold_chk_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_value("mrst_gate",  {31'd0, gate_en},        32'd0);
        check_value("mrst_start", {31'd0, bus.start_tx},   32'd0);
        check_value("mrst_data",  {24'd0, bus.data_to_tx}, 32'd0);
        check_value("mrst_ovr",   {31'd0, overrun},        32'd0);
        check_value("mrst_fault", {31'd0, tx_fault},       32'd0);
        check_value("mrst_err",   {24'd0, err_count},      32'd0);
        check_value("mrst_trip",  {31'd0, wdt_trip},       32'd0);
        reset = 1'b0;
        starts_before = n_start;
        repeat (12) @(negedge clk);
        check_value("mrst_nostart", n_start, starts_before);
        hold_chk_en = 1'b1;

        // err_count saturates at 255.
        for (int i = 0; i < 254; i++) begin
            send_byte(8'h00, 1'b0);
            repeat (12) @(negedge clk);
        end
        check_value("sat_254", {24'd0, err_count}, 32'd254);
        send_byte(8'h00, 1'b0);
        repeat (12) @(negedge clk);
        check_value("sat_255", {24'd0, err_count}, 32'd255);
        send_byte(8'h00, 1'b0);
        repeat (12) @(negedge clk);
        check_value("sat_hold", {24'd0, err_count}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter CMD_ON, default 8'b10101010, command byte that sets gate_en.
REQ-002 Parameter CMD_OFF, default 8'b01010101, command byte that clears gate_en.
REQ-003 Parameter CMD_TOGGLE, default 8'b11000011, command byte that inverts gate_en.
REQ-004 Parameter NACK, default 8'hFF, reply byte for a rejected frame.
REQ-005 Parameter WDT_CYCLES, default 48000000, number of cycles without a valid command before gate_en is forced off.
REQ-006 Parameter BUSY_TMO, default 16, cycles allowed for tx_busy to rise after start_tx.
REQ-007 clk  in  1  single system clock (48 MHz HFOSC); all logic on posedge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 data_received  in  8  byte from uart_rx, valid while rx_done=1.
REQ-010 rx_done  in  1  one-cycle strobe, new byte available.
REQ-011 parity_error  in  1  parity flag from uart_rx, qualified by rx_done.
REQ-012 tx_busy  in  1  uart_tx is shifting a frame.
REQ-013 data_to_tx  out  8  reply byte to uart_tx, held stable from start_tx until tx_busy falls.
REQ-014 start_tx  out  1  one-cycle request to uart_tx.
REQ-015 gate_en  out  1  registered enable for the SPWM stage.
REQ-016 wdt_trip  out  1  one-cycle pulse when the watchdog clears gate_en.
REQ-017 overrun  out  1  sticky flag: rx_done arrived outside IDLE.
REQ-018 tx_fault  out  1  sticky flag: tx_busy failed to rise within BUSY_TMO.
REQ-019 err_count  out  8  saturating count of rejected frames.

Function
REQ-020 FSM states SHALL be IDLE, DECODE, SEND, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-021 IDLE: rx_done=1 -> latch data_received and parity_error, go to DECODE next cycle.
REQ-022 DECODE lasts exactly one cycle and goes to SEND.
REQ-023 DECODE with latched parity_error=1 -> reply NACK; gate_en unchanged; err_count+1.
REQ-024 DECODE with a byte equal to CMD_ON, CMD_OFF or CMD_TOGGLE -> apply the action to gate_en; reply = the received byte (echo); watchdog cleared.
REQ-025 DECODE with any other byte -> reply NACK; gate_en unchanged; err_count+1.
REQ-026 err_count SHALL saturate at 255; no wrap.
REQ-027 Latency: rx_done sampled at cycle N -> gate_en updated at N+2 -> start_tx=1 at N+3 when tx_busy=0 at N+2.
REQ-028 SEND: data_to_tx driven with the reply; start_tx asserted for exactly one cycle only when tx_busy=0; otherwise wait in SEND.
REQ-029 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; BUSY_TMO cycles without tx_busy -> set tx_fault, return to IDLE.
REQ-030 WAIT_DONE: tx_busy=0 -> IDLE; data_to_tx SHALL stay constant until then.
REQ-031 rx_done in any state other than IDLE -> byte discarded, overrun set; the current transaction continues.
REQ-032 Watchdog: a 32-bit counter increments every cycle, clears on valid command; on reaching WDT_CYCLES-1 it clears; if gate_en=1 at that point, gate_en<=0 and wdt_trip pulses.
REQ-033 Valid command in DECODE on the watchdog expiry cycle -> the command wins; no wdt_trip.
REQ-034 Watchdog runs in every FSM state.

Reset
REQ-035 reset=1 -> state IDLE; gate_en=0, start_tx=0, data_to_tx=8'h00, wdt_trip=0, overrun=0, tx_fault=0, err_count=0, watchdog=0.
REQ-036 reset during SEND/WAIT_BUSY/WAIT_DONE aborts the transaction on the next edge; no start_tx issued after it.
REQ-037 Sticky flags clear only on reset.

Verification
REQ-038 rx_done with 8'hAA, parity 0, tx_busy model responsive -> gate_en=1 at N+2, start_tx pulse at N+3, data_to_tx=8'hAA.
REQ-039 8'hC3 twice after CMD_ON -> gate_en 1->0->1; two echoes of 8'hC3.
REQ-040 8'hAA with parity_error=1, then 8'h12 -> gate_en unchanged, two NACK 8'hFF replies, err_count=2.
REQ-041 Second rx_done while in WAIT_DONE -> overrun=1, byte ignored, single reply sent.
REQ-042 WDT_CYCLES=100, CMD_ON then silence -> gate_en=0 with wdt_trip pulse 100 cycles after counter clear; CMD_ON on the expiry cycle -> no trip.
REQ-043 tx_busy held 0 after start_tx -> tx_fault=1 after 16 cycles, FSM in IDLE; reset mid-WAIT_DONE -> all outputs at reset values.
